// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor (diff = a - b, LSB first); optional signed overflow flag under SERIAL_SUB_OVF_EN

// Single-bit full subtractor: difference = a - b - borrow_in.
module full_subtractor (
    output logic difference,
    output logic borrow,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);
    assign difference = a ^ b ^ borrow_in;
    assign borrow     = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// Bit-serial sequencer around one full_subtractor cell.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             cell_diff;
    logic             cell_borrow;

    full_subtractor u_fs (cell_diff, cell_borrow, a_sr_q[0], b_sr_q[0], borrow_q);

    // Next-state: accept in IDLE/DONE, shift one bit per cycle in SHIFT, publish on the last bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d    = {cell_diff, res_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = cell_borrow;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    diff_d  = res_d;
                    bout_d  = cell_borrow;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
    logic accept;
    logic finish;

    assign accept = (state_q != S_SHIFT) && start;
    assign finish = (state_q == S_SHIFT) && (cnt_q == LAST);

    // Operand sign bits captured at accept; overflow judged from them and the final MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b[WIDTH-1];
            end
            if (finish) begin
                ovf_q <= (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
